link_rx: RTL and testbench



---
 rtl/link_pkg.sv | 10 +
 rtl/link_rx_fifo.sv | 37 +++
 rtl/link_rx.sv | 113 +++++++++++
 tb/tb_link_rx.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/link_pkg.sv
// link_pkg: shared receiver state encoding, status bit positions and default register addresses.
package link_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;
  localparam int ST_VALID = 7;
  localparam int ST_OVR = 6;
  localparam int ST_FERR = 5;
  localparam int ST_PERR = 4;
  localparam logic [15:0] DATA_ADDR_DEF = 16'hff03;
  localparam logic [15:0] STAT_ADDR_DEF = 16'hff08;
endpackage

// File: rtl/link_rx_fifo.sv
// link_rx_fifo: small single-clock byte FIFO; a push into a full FIFO only lands when a pop frees a slot in the same cycle.
module link_rx_fifo import link_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                     clockgb,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clockgb)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clockgb) begin
    if (!resetn) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/link_rx.sv
// link_rx: 16x-oversampled UART receiver with byte FIFO and data/status registers.
// Define LINK_RX_PARITY_EN for 8E1 framing with a PERR status flag; default is 8N1.
module link_rx import link_pkg::*; #(
  parameter int          CLK_HZ    = 4194304,
  parameter int          BAUD      = 115200,
  parameter int          DEPTH     = 4,
  parameter logic [15:0] DATA_ADDR = DATA_ADDR_DEF,
  parameter logic [15:0] STAT_ADDR = STAT_ADDR_DEF
) (
  input  logic        clockgb,
  input  logic        resetn,
  input  logic [15:0] address,
  input  logic [7:0]  indata,
  output logic [7:0]  outdata,
  input  logic        load,
  input  logic        store,
  input  logic        UART_RX,
  output logic        irq
);
`ifdef LINK_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int AW = $clog2(CLK_HZ) + 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [AW:0] INC = (AW+1)'(16 * BAUD);
  localparam logic [AW:0] LIM = (AW+1)'(CLK_HZ);
  rx_state_t state, nxt;
  logic [AW-1:0] acc;
  logic [AW:0] sum, acc_nx;
  logic [1:0] sync;
  logic [3:0] os;
  logic [2:0] bitn;
  logic [7:0] shreg, dout;
  logic [CW-1:0] cnt_f;
  logic [2:0] wclr;
  logic rx, tick, mid, last, clr, shift, stop_ok, ferr_set, perr_set, ovr_set;
  logic push_q, load_q, pop, empty, full, ovr, ferr, perr, rd_d, rd_s;
  logic unused;
  assign rx = sync[1];
  assign sum = {1'b0, acc} + INC;
  assign tick = sum >= LIM;
  assign acc_nx = tick ? sum - LIM : sum;
  assign unused = ^{indata[7], indata[3:0], indata[ST_PERR]};
  always_ff @(posedge clockgb)
    state <= !resetn ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:   if (!rx) nxt = START;
      START:  if (mid) nxt = rx ? IDLE : DATA;
      DATA:   if (last && bitn == 3'd7) nxt = PAR_EN ? PARITY : STOP;
`ifdef LINK_RX_PARITY_EN
      PARITY: if (last) nxt = STOP;
`endif
      STOP:   if (last) nxt = rx ? IDLE : BREAK;
      BREAK:  if (rx) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    mid = tick && os == 4'd7;
    last = tick && os == 4'd15;
    clr = state == IDLE && !rx;
    shift = state == DATA && last;
    stop_ok = state == STOP && last && rx;
    ferr_set = state == STOP && last && !rx;
`ifdef LINK_RX_PARITY_EN
    perr_set = state == PARITY && last && (rx != ^shreg);
`else
    perr_set = 1'b0;
`endif
  end
  // A pop on the same edge frees the slot, so a push into a full FIFO is then not an overrun.
  assign pop = load && !load_q && address == DATA_ADDR;
  assign irq = push_q && (!full || pop);
  assign ovr_set = push_q && full && !pop;
  assign wclr = store && address == STAT_ADDR ? indata[ST_OVR:ST_PERR] : 3'b000;
  always_ff @(posedge clockgb) begin
    if (!resetn) begin
      sync <= 2'b11;
      acc <= '0;
      os <= '0;
      bitn <= '0;
      shreg <= '0;
      push_q <= 1'b0;
      load_q <= 1'b0;
      ovr <= 1'b0;
      ferr <= 1'b0;
      perr <= 1'b0;
    end else begin
      sync <= {sync[0], UART_RX};
      load_q <= load;
      push_q <= stop_ok;
      acc <= clr ? '0 : acc_nx[AW-1:0];
      os <= (clr || (state == START && mid)) ? 4'd0 : tick ? os + 4'd1 : os;
      bitn <= clr ? 3'd0 : shift ? bitn + 3'd1 : bitn;
      if (shift) shreg <= {rx, shreg[7:1]};
      ovr <= (ovr && !wclr[2]) || ovr_set;
      ferr <= (ferr && !wclr[1]) || ferr_set;
      perr <= (perr && !wclr[0]) || perr_set;
    end
  end
  link_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clockgb(clockgb), .resetn(resetn), .push(push_q), .pop(pop), .din(shreg),
    .dout(dout), .empty(empty), .full(full), .count(cnt_f)
  );
  assign rd_d = load && address == DATA_ADDR;
  assign rd_s = load && address == STAT_ADDR;
  assign outdata = rd_d ? (empty ? 8'hff : dout)
                 : rd_s ? {!empty, ovr, ferr, perr, 1'b0, 3'(cnt_f)} : 8'h00;
endmodule

// File: tb/tb_link_rx.sv
// tb_link_rx: directed serial frames; reads queue their expected value and a negedge monitor checks them.
module tb_link_rx;
  localparam longint CLK = 4194304;
  localparam longint BAUD = 115200;
  localparam logic [15:0] DA = 16'hff03;
  localparam logic [15:0] SA = 16'hff08;
`ifdef LINK_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int NB = PAR ? 11 : 10;
  logic clockgb = 0, resetn = 0, load = 0, store = 0, UART_RX = 1;
  logic [15:0] address = '0;
  logic [7:0] indata = '0;
  logic [7:0] outdata;
  logic irq;
  typedef struct { string name; logic [7:0] val; } exp_t;
  exp_t q[$];
  int total = 0, bad = 0, irq_cnt = 0;
  link_rx dut (
    .clockgb(clockgb), .resetn(resetn), .address(address), .indata(indata),
    .outdata(outdata), .load(load), .store(store), .UART_RX(UART_RX), .irq(irq)
  );
  always #5 clockgb = ~clockgb;
  function automatic void check(string n, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h want %02h", n, act, exp);
    end
  endfunction
  always @(negedge clockgb) begin
    if (irq) irq_cnt++;
    if (load) begin
      if (q.size() == 0) check("unexpected read", outdata, 8'hxx);
      else begin
        exp_t e;
        e = q.pop_front();
        check(e.name, outdata, e.val);
      end
    end
  end
  task automatic cyc(int n);
    repeat (n) @(posedge clockgb);
    #1;
  endtask
  task automatic rd(logic [15:0] a, logic [7:0] e, string n);
    q.push_back('{n, e});
    address = a;
    load = 1;
    cyc(1);
    load = 0;
    address = '0;
    cyc(1);
  endtask
  task automatic wr(logic [15:0] a, logic [7:0] d);
    address = a;
    indata = d;
    store = 1;
    cyc(1);
    store = 0;
    address = '0;
    cyc(1);
  endtask
  // rst_bit >= 0 holds resetn low from the middle of that frame bit to the end of the frame.
  task automatic send(logic [7:0] b, int skew, bit badpar, int rst_bit);
    logic [10:0] bits;
    longint t0, t1;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = b;
    if (PAR) bits[9] = ^b ^ badpar;
    t0 = 0;
    for (int i = 0; i < NB; i++) begin
      t1 = (i + 1) * CLK * (100 + skew) / (BAUD * 100);
      UART_RX = bits[i];
      if (i == rst_bit) begin
        cyc(int'((t1 - t0) / 2));
        resetn = 0;
        cyc(int'(t1 - t0 - (t1 - t0) / 2));
      end else cyc(int'(t1 - t0));
      t0 = t1;
    end
    resetn = 1;
    UART_RX = 1;
    cyc(4);
  endtask
  initial begin
    int i0;
    cyc(4);
    resetn = 1;
    cyc(2);
    check("irq reset", {7'd0, irq}, 8'h00);
    check("idle bus", outdata, 8'h00);
    rd(SA, 8'h00, "stat reset");
    rd(DA, 8'hff, "data empty");
    rd(16'hff00, 8'h00, "other addr");
    i0 = irq_cnt;
    send(8'hA5, 0, 0, -1);
    check("irq a5", 8'(irq_cnt - i0), 8'd1);
    rd(SA, 8'h81, "stat a5");
    rd(DA, 8'hA5, "data a5");
    rd(SA, 8'h00, "stat after pop");
    i0 = irq_cnt;
    UART_RX = 0;
    cyc(3);
    UART_RX = 1;
    cyc(100);
    check("irq glitch", 8'(irq_cnt - i0), 8'd0);
    rd(SA, 8'h00, "stat glitch");
    i0 = irq_cnt;
    for (int k = 1; k <= 5; k++) send(8'(k), 0, 0, -1);
    check("irq burst", 8'(irq_cnt - i0), 8'd4);
    rd(SA, 8'hC4, "stat overrun");
    for (int k = 1; k <= 4; k++) rd(DA, 8'(k), "data burst");
    rd(DA, 8'hff, "data drained");
    wr(SA, 8'h40);
    rd(SA, 8'h00, "stat ovr clr");
    i0 = irq_cnt;
    UART_RX = 0;
    cyc(2 * NB * 37);
    UART_RX = 1;
    cyc(40);
    check("irq break", 8'(irq_cnt - i0), 8'd0);
    rd(SA, 8'h20, "stat break");
    send(8'h3C, 0, 0, -1);
    check("irq 3c", 8'(irq_cnt - i0), 8'd1);
    rd(SA, 8'hA1, "stat ferr");
    wr(SA, 8'h20);
    rd(SA, 8'h81, "stat ferr clr");
    rd(DA, 8'h3C, "data 3c");
    i0 = irq_cnt;
    send(8'h11, 0, 0, -1);
    send(8'h77, 0, 0, 5);
    send(8'h5A, 0, 0, -1);
    check("irq reset frame", 8'(irq_cnt - i0), 8'd2);
    rd(SA, 8'h81, "stat after reset");
    rd(DA, 8'h5A, "data 5a");
    rd(DA, 8'hff, "no fragment");
    send(8'h55, 2, 0, -1);
    rd(SA, 8'h81, "stat slow");
    rd(DA, 8'h55, "data slow");
    send(8'h55, -2, 0, -1);
    rd(SA, 8'h81, "stat fast");
    rd(DA, 8'h55, "data fast");
`ifdef LINK_RX_PARITY_EN
    send(8'h03, 0, 1, -1);
    rd(SA, 8'h91, "stat perr");
    rd(DA, 8'h03, "data perr");
    wr(SA, 8'h10);
    rd(SA, 8'h00, "stat perr clr");
`endif
    cyc(4);
    check("queue drained", 8'(q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
